// File: rtl/price_win_pkg.sv
// Shared constants and state encoding for the price-window buffer and the indicator blocks.
// Optional running-sum feature is enabled with PRICE_WIN_SUM_EN (see price_window_buf).
package price_win_pkg;

  localparam int unsigned CNT_W      = 5;
  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned DEF_WINDOW = 14;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StEmit = EMIT,
    StWait = WAIT
  } state_e;

endpackage

// File: rtl/price_window_buf_if.sv
// Price-window interface between upstream source, buffer and indicator consumer.
// window_sum is present only when PRICE_WIN_SUM_EN is defined.
interface price_window_buf_if
  import price_win_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
);
  logic             in_valid;
  logic [DW-1:0]    in_price;
  logic             in_ready;
  logic             flush;
  logic             consumer_done;
  logic             new_price_strobe;
  logic [DW-1:0]    new_price;
  logic [DW-1:0]    oldest_price;
  logic             mem_full;
  logic [CNT_W-1:0] mem_count;
`ifdef PRICE_WIN_SUM_EN
  logic [DW+4:0]    window_sum;
`endif

  // Upstream source plus indicator side
  modport master (
    output in_valid, in_price, flush, consumer_done,
    input  in_ready, new_price_strobe, new_price, oldest_price, mem_full, mem_count
`ifdef PRICE_WIN_SUM_EN
    , input window_sum
`endif
  );

  // The buffer itself
  modport slave (
    input  in_valid, in_price, flush, consumer_done,
    output in_ready, new_price_strobe, new_price, oldest_price, mem_full, mem_count
`ifdef PRICE_WIN_SUM_EN
    , output window_sum
`endif
  );

endinterface

// File: rtl/price_win_ram.sv
// Window storage: DEPTH x DW register array, one write port and an asynchronous read
// at the same address, so the old word is visible at the write edge.
module price_win_ram #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 14,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/price_window_buf.sv
// Circular price-window buffer: accepts samples, strobes new/evicted price to the indicators
// and holds off upstream until the consumer is done. PRICE_WIN_SUM_EN adds a running window_sum.
module price_window_buf
  import price_win_pkg::*;
#(
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned WINDOW       = DEF_WINDOW,
  parameter int unsigned DONE_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  price_window_buf_if.slave bus
);

  localparam int unsigned AW = $clog2(WINDOW);

  state_e           state_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    ptr_inc;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;
  logic             full_q;
  logic             strobe_q;
  logic [DW-1:0]    new_q;
  logic [DW-1:0]    oldest_q;
  logic [7:0]       timer_q;
  logic [DW-1:0]    rd_data;
  logic             accept;

  // Flush has priority, so a sample presented with flush is never written
  assign accept = (state_q == StIdle) && bus.in_valid && !bus.flush;

  always_comb begin
    ptr_inc   = (wr_ptr_q == AW'(WINDOW - 1)) ? '0 : wr_ptr_q + 1'b1;
    count_inc = (count_q == CNT_W'(WINDOW)) ? count_q : count_q + 1'b1;
  end

  price_win_ram #(
    .DW    (DW),
    .DEPTH (WINDOW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (wr_ptr_q),
    .wdata (bus.in_price),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      strobe_q <= 1'b0;
      new_q    <= '0;
      oldest_q <= '0;
      timer_q  <= '0;
    end else if (bus.flush) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      strobe_q <= 1'b0;
      oldest_q <= '0;
      timer_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            new_q    <= bus.in_price;
            oldest_q <= full_q ? rd_data : '0;
            wr_ptr_q <= ptr_inc;
            count_q  <= count_inc;
            full_q   <= (count_inc == CNT_W'(WINDOW));
            strobe_q <= 1'b1;
            state_q  <= StEmit;
          end
        end
        StEmit: begin
          // Only a full window makes the consumer do work worth waiting for
          if (!full_q || bus.consumer_done) begin
            state_q <= StIdle;
          end else begin
            state_q <= StWait;
            timer_q <= '0;
          end
        end
        StWait: begin
          if (bus.consumer_done || timer_q == 8'(DONE_TIMEOUT - 1)) begin
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready         = (state_q == StIdle);
  assign bus.new_price_strobe = strobe_q;
  assign bus.new_price        = new_q;
  assign bus.oldest_price     = oldest_q;
  assign bus.mem_full         = full_q;
  assign bus.mem_count        = count_q;

`ifdef PRICE_WIN_SUM_EN
  localparam int unsigned SW = DW + 5;

  logic [SW-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (bus.flush) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + SW'(bus.in_price) - (full_q ? SW'(rd_data) : '0);
    end
  end

  assign bus.window_sum = sum_q;
`endif

endmodule

// File: tb/tb_price_window_buf.sv
// Self-checking bench for price_window_buf: vector table plus strobe scoreboard.
// Sum checks are compiled in when PRICE_WIN_SUM_EN is defined.
module tb_price_window_buf;

  typedef struct {
    logic [15:0] price;
    logic [4:0]  cnt;
    logic        full;
    logic [15:0] oldest;
    logic [20:0] sum;
  } vec_t;

  typedef struct {
    logic [15:0] np;
    logic [15:0] op;
    logic [4:0]  cnt;
    logic        full;
    logic        sum_en;
    logic [20:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  price_window_buf_if #(.DW(16)) bus ();

  price_window_buf #(
    .DW           (16),
    .WINDOW       (14),
    .DONE_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.new_price_strobe) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("new_price", 32'(bus.new_price), 32'(e.np));
        chk("oldest_price", 32'(bus.oldest_price), 32'(e.op));
        chk("mem_count", 32'(bus.mem_count), 32'(e.cnt));
        chk("mem_full", 32'(bus.mem_full), 32'(e.full));
`ifdef PRICE_WIN_SUM_EN
        if (e.sum_en) chk("window_sum", 32'(bus.window_sum), 32'(e.sum));
`endif
      end
    end
  end

  // Entered just after a negedge; returns at the negedge of the strobe cycle.
  task automatic push(input logic [15:0] p, input logic [15:0] eo, input logic [4:0] ec,
                      input logic ef, input logic se, input logic [20:0] es);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_price = p;
    sb.push_back('{np: p, op: eo, cnt: ec, full: ef, sum_en: se, sum: es});
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("strobe_latency", 32'(bus.new_price_strobe), 32'd1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_strobe"}, 32'(bus.new_price_strobe), 32'd0);
    chk({tag, "_new_price"}, 32'(bus.new_price), 32'd0);
    chk({tag, "_oldest"}, 32'(bus.oldest_price), 32'd0);
    chk({tag, "_full"}, 32'(bus.mem_full), 32'd0);
    chk({tag, "_count"}, 32'(bus.mem_count), 32'd0);
`ifdef PRICE_WIN_SUM_EN
    chk({tag, "_sum"}, 32'(bus.window_sum), 32'd0);
`endif
  endtask

  initial begin
    int low;
    bus.in_valid      = 1'b0;
    bus.in_price      = '0;
    bus.flush         = 1'b0;
    bus.consumer_done = 1'b0;

    for (int i = 0; i < 15; i++) begin
      vecs[i].price  = 16'(i + 1);
      vecs[i].cnt    = (i < 14) ? 5'(i + 1) : 5'd14;
      vecs[i].full   = (i >= 13);
      vecs[i].oldest = (i == 14) ? 16'd1 : 16'd0;
      vecs[i].sum    = (i < 14) ? 21'((i + 1) * (i + 2) / 2) : 21'd119;
    end

    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fill 1..14, then evict the first sample with 15
    for (int i = 0; i < 15; i++) begin
      push(vecs[i].price, vecs[i].oldest, vecs[i].cnt, vecs[i].full, 1'b1, vecs[i].sum);
    end

    // Full window, consumer never answers: EMIT + DONE_TIMEOUT cycles of backpressure
    push(16'd16, 16'd2, 5'd14, 1'b1, 1'b0, '0);
    low = 0;
    while (!bus.in_ready && low < 50) begin
      low++;
      @(negedge clk);
    end
    chk("timeout_low_cycles", 32'(low), 32'd17);

    // consumer_done in the cycle after the strobe
    push(16'd17, 16'd3, 5'd14, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("wait_not_ready", 32'(bus.in_ready), 32'd0);
    bus.consumer_done = 1'b1;
    @(negedge clk);
    bus.consumer_done = 1'b0;
    chk("done_in_wait_ready", 32'(bus.in_ready), 32'd1);

    // consumer_done during the strobe cycle itself
    push(16'd18, 16'd4, 5'd14, 1'b1, 1'b0, '0);
    bus.consumer_done = 1'b1;
    @(negedge clk);
    bus.consumer_done = 1'b0;
    chk("done_in_emit_ready", 32'(bus.in_ready), 32'd1);

    // Reset asserted while waiting for the consumer
    push(16'd19, 16'd5, 5'd14, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("pre_reset_wait", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_idle_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    chk_idle_zero("rst_wait");

    for (int i = 0; i < 9; i++) begin
      push(16'(21 + i), 16'd0, 5'(i + 1), 1'b0, 1'b0, '0);
    end
    @(negedge clk);
    chk("pre_flush_count", 32'(bus.mem_count), 32'd9);

    // flush wins over a simultaneous sample
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_price = 16'd99;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 32'(bus.mem_count), 32'd0);
    chk("flush_strobe", 32'(bus.new_price_strobe), 32'd0);
    chk("flush_full", 32'(bus.mem_full), 32'd0);
    chk("flush_oldest", 32'(bus.oldest_price), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PRICE_WIN_SUM_EN
    chk("flush_sum", 32'(bus.window_sum), 32'd0);
`endif
    @(negedge clk);
    chk("flush_no_late_strobe", 32'(bus.new_price_strobe), 32'd0);

    push(16'd7, 16'd0, 5'd1, 1'b0, 1'b1, 21'd7);
    // Refill after flush: the 15th sample must evict 7 from slot 0
    for (int i = 0; i < 13; i++) begin
      push(16'(40 + i), 16'd0, 5'(i + 2), (i == 12), 1'b0, '0);
    end
    push(16'd60, 16'd7, 5'd14, 1'b1, 1'b0, '0);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
